seg7_scan_ctrl: RTL and testbench

//  Scan scheduler for the 4-digit multiplexed 7-segment display.

---
 rtl/seg7_wr_if.sv | 11 +
 rtl/seg7_scan_ctrl.sv | 179 +++++++++++++++++
 tb/tb_seg7_scan_ctrl.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/seg7_wr_if.sv
// Write port of the 7-segment scan controller: a producer offers a 16-bit
// display value with wr_valid and the controller takes it when wr_ready is
// high in the same cycle.
interface seg7_wr_if;
    logic        wr_valid;
    logic        wr_ready;
    logic [15:0] wr_data;

    modport master (output wr_valid, output wr_data, input wr_ready);
    modport slave  (input wr_valid, input wr_data, output wr_ready);
endinterface

// File: rtl/seg7_scan_ctrl.sv
// Scan scheduler for a 4-digit multiplexed 7-segment display.
// Each digit slot lasts SCAN_DIV clocks; the first GUARD clocks keep every
// anode off to stop ghosting, and the rest of the slot is PWM-dimmed by
// 'bright'. New values are double-buffered (pending -> disp) and only swap
// on the last cycle of slot 3, so a frame never mixes old and new digits.
// Optional build macro: LEAD_ZERO_BLANK_EN blanks leading zero digits
// (digit 0 is always shown); slot timing is identical either way.
module seg7_scan_ctrl #(
    parameter logic [15:0] SCAN_DIV = 16'd50000,
    parameter logic [7:0]  GUARD    = 8'd64
) (
    input  logic       CLK,
    input  logic       RST,
    seg7_wr_if.slave   wr,
    input  logic [3:0] bright,
    output logic [3:0] digit_o,
    output logic [1:0] slot_o,
    output logic       frame_o,
    output logic [3:0] an_o
);

    typedef enum logic [0:0] {
        ST_GUARD = 1'b0,
        ST_ON    = 1'b1
    } state_t;

    localparam logic [15:0] CNT_LAST = SCAN_DIV - 16'd1;
    localparam logic [15:0] GUARD16  = {8'd0, GUARD};

    state_t      state_r, state_nxt_s;
    logic [15:0] slot_cnt_r, slot_cnt_nxt_s;
    logic [1:0]  slot_r, slot_nxt_s;
    logic [3:0]  pwm_cnt_r, pwm_nxt_s;
    logic [15:0] disp_r, disp_nxt_s;
    logic [15:0] pend_r;
    logic        pend_full_r;
    logic [3:0]  an_r, an_nxt_s;
    logic [3:0]  digit_r, digit_nxt_s;
    logic        frame_r, frame_nxt_s;
    logic        cnt_wrap_s, boundary_s, accept_s, commit_s;

    // Slot is blanked when it and every higher digit hold zero (never digit 0).
    function automatic logic lead_blank(input logic [1:0] slot, input logic [15:0] disp);
`ifdef LEAD_ZERO_BLANK_EN
        case (slot)
            2'd3:    lead_blank = (disp[15:12] == 4'd0);
            2'd2:    lead_blank = (disp[15:8]  == 8'd0);
            2'd1:    lead_blank = (disp[15:4]  == 12'd0);
            default: lead_blank = 1'b0;
        endcase
`else
        lead_blank = 1'b0;
`endif
    endfunction

    // Nibble of the display word that belongs to a slot.
    function automatic logic [3:0] nibble_of(input logic [1:0] slot, input logic [15:0] disp);
        case (slot)
            2'd0:    nibble_of = disp[3:0];
            2'd1:    nibble_of = disp[7:4];
            2'd2:    nibble_of = disp[11:8];
            2'd3:    nibble_of = disp[15:12];
            default: nibble_of = 4'd0;
        endcase
    endfunction

    // Next values of the scan counters, handshake and frame-boundary commit.
    always_comb begin
        cnt_wrap_s     = (slot_cnt_r == CNT_LAST);
        slot_cnt_nxt_s = cnt_wrap_s ? 16'd0 : (slot_cnt_r + 16'd1);
        slot_nxt_s     = cnt_wrap_s ? (slot_r + 2'd1) : slot_r;
        boundary_s     = cnt_wrap_s && (slot_r == 2'd3);
        pwm_nxt_s      = pwm_cnt_r + 4'd1;
        accept_s       = wr.wr_valid && !pend_full_r;
        commit_s       = boundary_s && pend_full_r;
        disp_nxt_s     = commit_s ? pend_r : disp_r;
    end

    // Scan counters: slot position, slot index and free-running PWM phase.
    always_ff @(posedge CLK) begin
        if (RST) begin
            slot_cnt_r <= 16'd0;
            slot_r     <= 2'd0;
            pwm_cnt_r  <= 4'd0;
        end else begin
            slot_cnt_r <= slot_cnt_nxt_s;
            slot_r     <= slot_nxt_s;
            pwm_cnt_r  <= pwm_nxt_s;
        end
    end

    // FSM state register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r <= ST_GUARD;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next state: GUARD covers slot_cnt < GUARD, ON the rest of the slot.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_GUARD: begin
                if (slot_cnt_nxt_s >= GUARD16) begin
                    state_nxt_s = ST_ON;
                end else begin
                    state_nxt_s = ST_GUARD;
                end
            end
            ST_ON: begin
                if (cnt_wrap_s) begin
                    state_nxt_s = ST_GUARD;
                end else begin
                    state_nxt_s = ST_ON;
                end
            end
            default: state_nxt_s = ST_GUARD;
        endcase
    end

    // FSM outputs, computed one cycle ahead so the output registers line up
    // with the counters they describe.
    always_comb begin
        an_nxt_s = 4'b1111;
        if ((state_nxt_s == ST_ON) && (pwm_nxt_s < bright) &&
            !lead_blank(slot_nxt_s, disp_nxt_s)) begin
            an_nxt_s[slot_nxt_s] = 1'b0;
        end else begin
            an_nxt_s = 4'b1111;
        end

        if (slot_cnt_nxt_s == 16'd0) begin
            digit_nxt_s = nibble_of(slot_nxt_s, disp_nxt_s);
        end else begin
            digit_nxt_s = digit_r;
        end

        frame_nxt_s = (slot_nxt_s == 2'd3) && (slot_cnt_nxt_s == CNT_LAST);
    end

    // Pending buffer and displayed word; a full pending word blocks new writes.
    always_ff @(posedge CLK) begin
        if (RST) begin
            pend_r      <= 16'd0;
            pend_full_r <= 1'b0;
            disp_r      <= 16'd0;
        end else if (commit_s) begin
            disp_r      <= pend_r;
            pend_full_r <= 1'b0;
        end else if (accept_s) begin
            pend_r      <= wr.wr_data;
            pend_full_r <= 1'b1;
        end else begin
            pend_full_r <= pend_full_r;
        end
    end

    // Output registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            an_r    <= 4'b1111;
            digit_r <= 4'd0;
            frame_r <= 1'b0;
        end else begin
            an_r    <= an_nxt_s;
            digit_r <= digit_nxt_s;
            frame_r <= frame_nxt_s;
        end
    end

    assign an_o        = an_r;
    assign digit_o     = digit_r;
    assign frame_o     = frame_r;
    assign slot_o      = slot_r;
    assign wr.wr_ready = ~pend_full_r;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Bench for seg7_scan_ctrl with SCAN_DIV=8, GUARD=2. The driver pushes each
// accepted write into a scoreboard queue; the monitor pops it on the frame
// pulse that commits it and checks digits, anodes, slot, frame and ready.
module tb_seg7_scan_ctrl;

    localparam logic [15:0] SD = 16'd8;
    localparam logic [7:0]  GD = 8'd2;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [3:0] bright = 4'd15;
    logic [3:0] digit_o;
    logic [1:0] slot_o;
    logic       frame_o;
    logic [3:0] an_o;

    seg7_wr_if wr_bus ();

    seg7_scan_ctrl #(.SCAN_DIV(SD), .GUARD(GD)) dut (
        .CLK     (CLK),
        .RST     (RST),
        .wr      (wr_bus),
        .bright  (bright),
        .digit_o (digit_o),
        .slot_o  (slot_o),
        .frame_o (frame_o),
        .an_o    (an_o)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [15:0] data;
        int          cyc;
    } item_t;

    item_t sb_q[$];
    int total = 0;
    int bad   = 0;

    // Reference scan timing
    int         cyc     = 0;
    int         m_cnt   = 0;
    logic [1:0] m_slot  = 2'd0;
    logic [3:0] m_pwm   = 4'd0;
    logic [3:0] m_br    = 4'd0;
    logic       m_rst_d = 1'b0;

    always @(posedge CLK) begin
        cyc     <= cyc + 1;
        m_br    <= bright;
        m_rst_d <= RST;
        if (RST) begin
            m_cnt  <= 0;
            m_slot <= 2'd0;
            m_pwm  <= 4'd0;
        end else begin
            m_pwm <= m_pwm + 4'd1;
            if (m_cnt == 7) begin
                m_cnt  <= 0;
                m_slot <= m_slot + 2'd1;
            end else begin
                m_cnt <= m_cnt + 1;
            end
        end
    end

    function automatic logic tb_blank(input logic [1:0] slot, input logic [15:0] d);
`ifdef LEAD_ZERO_BLANK_EN
        if (slot == 2'd3) return d[15:12] == 4'd0;
        if (slot == 2'd2) return d[15:8] == 8'd0;
        if (slot == 2'd1) return d[15:4] == 12'd0;
        return 1'b0;
`else
        return 1'b0;
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d slot %0d cnt %0d)",
                     name, act, exp, cyc, m_slot, m_cnt);
        end
    endtask

    // Monitor: per-cycle checks, pops the scoreboard on a committing frame pulse
    initial begin : monitor
        logic [15:0] cur_disp;
        logic [15:0] sh;
        logic [3:0]  exp_an;
        bit          en;
        item_t       it;
        cur_disp = 16'd0;
        en = 1'b0;
        forever begin
            @(negedge CLK);
            if (m_rst_d) begin
                en = 1'b1;
                cur_disp = 16'd0;
                sb_q.delete();
            end
            if (en) begin
                sh = cur_disp >> (4 * m_slot);
                exp_an = 4'b1111;
                if (m_cnt >= 2 && m_pwm < m_br && !tb_blank(m_slot, cur_disp))
                    exp_an[m_slot] = 1'b0;
                check("slot_o", {30'd0, slot_o}, {30'd0, m_slot});
                check("frame_o", {31'd0, frame_o}, {31'd0, (m_slot == 2'd3 && m_cnt == 7)});
                check("digit_o", {28'd0, digit_o}, {28'd0, sh[3:0]});
                check("an_o", {28'd0, an_o}, {28'd0, exp_an});
                check("wr_ready", {31'd0, wr_bus.wr_ready}, {31'd0, (sb_q.size() == 0)});
                if (frame_o && sb_q.size() > 0) begin
                    it = sb_q.pop_front();
                    check("latency_ok", {31'd0, ((cyc + 1 - it.cyc) <= 33 && (cyc + 1 - it.cyc) >= 1)}, 32'd1);
                    cur_disp = it.data;
                end
            end
        end
    end

    task automatic do_write(input logic [15:0] d);
        bit done;
        done = 1'b0;
        wr_bus.wr_valid = 1'b1;
        wr_bus.wr_data  = d;
        for (int i = 0; i < 200 && !done; i++) begin
            @(posedge CLK);
            if (wr_bus.wr_ready && !RST) begin
                sb_q.push_back('{d, cyc});
                done = 1'b1;
            end
        end
        #1;
        wr_bus.wr_valid = 1'b0;
        total++;
        if (!done) begin
            bad++;
            $display("FAIL write_accept: got no accept expected accept of %0h", d);
        end
    endtask

    task automatic wait_frames(input int n);
        int seen;
        seen = 0;
        for (int i = 0; i < n * 40 && seen < n; i++) begin
            @(negedge CLK);
            if (frame_o) seen++;
        end
        total++;
        if (seen < n) begin
            bad++;
            $display("FAIL frame_wait: got %0d frames expected %0d", seen, n);
        end
    endtask

    task automatic wait_slot(input logic [1:0] s);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < 40 && !hit; i++) begin
            @(negedge CLK);
            if (slot_o == s) hit = 1'b1;
        end
        total++;
        if (!hit) begin
            bad++;
            $display("FAIL slot_wait: got no slot %0d expected slot %0d", s, s);
        end
    endtask

    // Directed stimulus
    initial begin
        wr_bus.wr_valid = 1'b0;
        wr_bus.wr_data  = 16'd0;
        RST = 1'b1;
        repeat (2) @(posedge CLK);
        #1 RST = 1'b0;
        wait_frames(1);

        do_write(16'h1234);
        wait_frames(2);

        do_write(16'hAAAA);
        do_write(16'h5555);
        wait_frames(2);

        bright = 4'd0;
        wait_frames(2);
        bright = 4'd8;
        wait_frames(2);

        bright = 4'd5;
        do_write(16'h0007);
        wait_frames(2);
        do_write(16'h00A0);
        wait_frames(2);
        bright = 4'd15;
        do_write(16'hF000);
        wait_frames(2);
        do_write(16'h0000);
        wait_frames(2);

        do_write(16'h4321);
        wait_frames(1);
        do_write(16'h9876);
        wait_slot(2'd2);
        RST = 1'b1;
        @(posedge CLK);
        #1 RST = 1'b0;
        wait_frames(2);

        bright = 4'd12;
        do_write(16'h0B0C);
        wait_frames(2);
        repeat (3) @(posedge CLK);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
